// File: rtl/sc_drain_sched_pkg.sv
// Shared store-commit drain definitions: entry lifecycle encoding and sizing defaults.
package sc_drain_sched_pkg;

  localparam int STORE_COMMIT_SIZE   = 8;
  localparam int STORE_COUNTER_WIDTH = 3;
  localparam int STORE_COMMIT_THRESH = 6;
  localparam int STORE_BACKOFF_WIDTH = 2;

  typedef enum logic [2:0] {
    FREE    = 3'd0,
    AGING   = 3'd1,
    READY   = 3'd2,
    WRITING = 3'd3,
    BACKOFF = 3'd4
  } sc_entry_state_t;

  localparam logic [2:0] ST_FREE    = 3'd0;
  localparam logic [2:0] ST_AGING   = 3'd1;
  localparam logic [2:0] ST_READY   = 3'd2;
  localparam logic [2:0] ST_WRITING = 3'd3;
  localparam logic [2:0] ST_BACKOFF = 3'd4;

endpackage

// File: rtl/sc_drain_sched_entry.sv
// One commit-buffer entry: lifecycle FSM with idle-age and conflict-backoff counters.
module sc_drain_entry
  import sc_drain_sched_pkg::*;
#(
  parameter int AGE_W     = STORE_COUNTER_WIDTH,
  parameter int BACKOFF_W = STORE_BACKOFF_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_alloc,
  input  logic       i_touch,
  input  logic       i_force,
  input  logic       i_issue,
  input  logic       i_succ,
  input  logic       i_conf,
  output logic       o_eligible,
  output logic       o_valid,
  output logic       o_writing,
  output logic       o_err,
  output logic [2:0] o_state
);

  localparam logic [AGE_W-1:0]     AGE_MAX = '1;
  localparam logic [AGE_W-1:0]     AGE_ONE = AGE_W'(1);
  localparam logic [BACKOFF_W-1:0] BO_MAX  = '1;

  logic [2:0]           r_state;
  logic [AGE_W-1:0]     r_age;
  logic [BACKOFF_W-1:0] r_bo;
  logic                 w_elig;

  // A touch that would restart aging also withdraws the entry this cycle,
  // so freshly merged data is never written out on the same edge.
  always_comb begin
    w_elig = 1'b0;
    case (r_state)
      ST_AGING:   w_elig = i_force | ((r_age <= AGE_ONE) & ~i_touch);
      ST_READY:   w_elig = i_force | ~i_touch;
      ST_BACKOFF: w_elig = (r_bo == '0);
      default:    w_elig = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_FREE;
      r_age   <= '0;
      r_bo    <= '0;
    end else begin
      case (r_state)
        ST_FREE: begin
          if (i_alloc && !i_succ) begin
            r_state <= ST_AGING;
            r_age   <= AGE_MAX;
          end
        end
        ST_AGING: begin
          if (i_issue)              r_state <= ST_WRITING;
          else if (w_elig)          r_state <= ST_READY;
          else if (i_touch)         r_age   <= AGE_MAX;
          else if (r_age > AGE_ONE) r_age   <= r_age - 1'b1;
        end
        ST_READY: begin
          if (i_issue) begin
            r_state <= ST_WRITING;
          end else if (i_touch && !i_force) begin
            r_state <= ST_AGING;
            r_age   <= AGE_MAX;
          end
        end
        ST_WRITING: begin
          if (i_succ) begin
            r_state <= ST_FREE;
          end else if (i_conf) begin
            r_state <= ST_BACKOFF;
            r_bo    <= BO_MAX;
          end
        end
        ST_BACKOFF: begin
          if (i_issue)           r_state <= ST_WRITING;
          else if (r_bo != '0)   r_bo    <= r_bo - 1'b1;
        end
        default: r_state <= ST_FREE;
      endcase
    end
  end

  assign o_err = (i_alloc & (r_state != ST_FREE))
               | (i_alloc & i_succ)
               | (i_touch & (((r_state == ST_FREE) & ~i_alloc) | (r_state == ST_WRITING)))
               | ((i_succ | i_conf) & (r_state != ST_WRITING))
               | (i_succ & i_conf);

  assign o_eligible = w_elig;
  assign o_valid    = (r_state != ST_FREE);
  assign o_writing  = (r_state == ST_WRITING);
  assign o_state    = r_state;

endmodule

// File: rtl/sc_drain_sched.sv
// Store-commit drain scheduler: round-robin write-back issue to the DCache store port.
module sc_drain_sched
  import sc_drain_sched_pkg::*;
#(
  parameter int ENTRIES   = STORE_COMMIT_SIZE,
  parameter int IDX_W     = $clog2(ENTRIES),
  parameter int AGE_W     = STORE_COUNTER_WIDTH,
  parameter int THRESH    = STORE_COMMIT_THRESH,
  parameter int BACKOFF_W = STORE_BACKOFF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [ENTRIES-1:0]   alloc_en,
  input  logic [ENTRIES-1:0]   touch_en,
  input  logic                 cache_ready,
  output logic                 req_valid,
  output logic [IDX_W-1:0]     req_idx,
  input  logic                 resp_conflict,
  input  logic                 resp_success,
  input  logic [IDX_W-1:0]     resp_idx,
  output logic [ENTRIES-1:0]   valid_vec,
  output logic [ENTRIES-1:0]   writing_vec,
  output logic                 empty,
  output logic                 drain_done,
  output logic                 proto_err,
  output logic [3*ENTRIES-1:0] dbg_state
);

  localparam int CNT_W = IDX_W + 1;

  logic [ENTRIES-1:0] w_elig;
  logic [ENTRIES-1:0] w_issue_vec;
  logic [ENTRIES-1:0] w_succ_vec;
  logic [ENTRIES-1:0] w_conf_vec;
  logic [ENTRIES-1:0] w_err_vec;
  logic [IDX_W-1:0]   w_sel;
  logic               w_found;
  logic               w_issue;
  logic               w_force;
  logic [CNT_W-1:0]   w_cnt;

  logic [IDX_W-1:0]   r_ptr;
  logic               r_thresh;
  logic               r_req_valid;
  logic [IDX_W-1:0]   r_req_idx;
  logic               r_err;

  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      j = (int'(r_ptr) + i) % ENTRIES;
      if (!w_found && w_elig[j]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) w_cnt = w_cnt + CNT_W'(valid_vec[i]);
  end

  // Handshake: a request fires on any cycle with an eligible entry and
  // cache_ready high; req_valid/req_idx then report it one cycle later.
  // There is no back-pressure on the registered request itself.
  assign w_issue = w_found & cache_ready;
  assign w_force = flush | r_thresh;

  for (genvar k = 0; k < ENTRIES; k++) begin : g_entry
    assign w_issue_vec[k] = w_issue & (w_sel == IDX_W'(k));
    assign w_succ_vec[k]  = resp_success & (resp_idx == IDX_W'(k));
    assign w_conf_vec[k]  = resp_conflict & (resp_idx == IDX_W'(k));

    sc_drain_entry #(
      .AGE_W     (AGE_W),
      .BACKOFF_W (BACKOFF_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .i_alloc    (alloc_en[k]),
      .i_touch    (touch_en[k]),
      .i_force    (w_force),
      .i_issue    (w_issue_vec[k]),
      .i_succ     (w_succ_vec[k]),
      .i_conf     (w_conf_vec[k]),
      .o_eligible (w_elig[k]),
      .o_valid    (valid_vec[k]),
      .o_writing  (writing_vec[k]),
      .o_err      (w_err_vec[k]),
      .o_state    (dbg_state[3*k +: 3])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_thresh    <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_idx   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_thresh    <= (w_cnt > CNT_W'(THRESH));
      r_req_valid <= w_issue;
      r_err       <= r_err | (|w_err_vec);
      if (w_issue) begin
        r_req_idx <= w_sel;
        r_ptr     <= IDX_W'((int'(w_sel) + 1) % ENTRIES);
      end
    end
  end

  assign req_valid  = r_req_valid;
  assign req_idx    = r_req_idx;
  assign proto_err  = r_err;
  assign empty      = ~|valid_vec;
  assign drain_done = flush & empty;

endmodule

// File: doc/sc_drain_sched.md
Name: sc_drain_sched

Overview:
Scheduler that decides when and in what order store-commit-buffer entries are written back to the DCache. It tracks a per-entry lifecycle: FREE, AGING, READY, WRITING, BACKOFF. It issues one write request per cycle, round-robin, to the DCache store port, and handles conflict retries with backoff. It sits between the store commit buffer's entry bookkeeping and the DCache store interface, replacing ad-hoc counter/selector logic.

Parameters:
ENTRIES, 8, number of commit-buffer entries
IDX_W, 3, clog2(ENTRIES)
AGE_W, 3, idle-age counter width; an entry is reloaded to all-ones on write
THRESH, 6, occupancy above which all valid entries drain regardless of age
BACKOFF_W, 2, retry backoff counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  level; force-drain all valid entries
alloc_en  in  ENTRIES  one-hot-or-zero per port usage; entry becomes valid
touch_en  in  ENTRIES  entry data merged this cycle; restarts aging
cache_ready  in  1  DCache store port can accept a request this cycle
req_valid  out  1  write request issued (registered)
req_idx  out  IDX_W  entry index of request
resp_conflict  in  1  DCache rejected request resp_idx; retry later
resp_success  in  1  write of resp_idx completed; free entry
resp_idx  in  IDX_W  index for resp_conflict/resp_success
valid_vec  out  ENTRIES  entry non-FREE
writing_vec  out  ENTRIES  entry WRITING (commit buffer must not merge into these)
empty  out  1  no valid entries
drain_done  out  1  flush high and empty
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all entries FREE; age and backoff counters 0; RR pointer 0. req_valid, req_idx, proto_err, thresh_reg = 0; empty=1.
- Entry state transitions, all registered:
  - FREE→AGING on alloc_en[k]; age := all-ones.
  - AGING: age decrements by 1 each cycle while >1. touch_en[k] reloads all-ones.
  - AGING→READY when age==1, or thresh_reg, or flush. Evaluated combinationally; the entry is eligible the same cycle.
  - READY/eligible→WRITING when selected and cache_ready.
  - WRITING→FREE on resp_success.
  - WRITING→BACKOFF on resp_conflict; backoff := all-ones.
  - BACKOFF decrements each cycle; at 0 the entry is eligible again. Backoff is honoured even under flush.
  - touch_en on a READY entry returns it to AGING with age reloaded, unless flush or thresh_reg is set.
- Selection: among eligible entries, pick the first index at or after the RR pointer (wrapping). On issue, the pointer becomes sel+1 mod ENTRIES.
- Issue rules: at most one issue per cycle. req_valid/req_idx are registered, so an entry eligible at cycle t with cache_ready appears on req_valid at t+1. The state goes to WRITING at t+1. Multiple WRITING entries are allowed.
- thresh_reg: registered (popcount(valid_vec) > THRESH); one-cycle lag.
- Simultaneous events:
  - Alloc and touch same entry, same cycle: alloc semantics.
  - resp_success and alloc_en on the same index in one cycle: success frees, alloc is ignored, proto_err set. The entry is allocatable the following cycle.
  - resp_conflict and resp_success together: proto_err set; success wins.
- proto_err is also set by:
  - alloc_en to a non-FREE entry
  - touch_en to a FREE or WRITING entry
  - any response to an entry that is not WRITING

  Offending updates are otherwise ignored. proto_err clears only on reset.
- Reset mid-operation: all state cleared asynchronously. Outstanding DCache responses after reset are the DCache's responsibility; they set proto_err if they arrive.
- drain_done = flush & empty (combinational). valid_vec, writing_vec and empty are direct decodes of the state registers.

Decomposition:
- Shared lsu package:
  - sc_entry_state_t enum {FREE, AGING, READY, WRITING, BACKOFF}
  - STORE_COMMIT_SIZE / STORE_COUNTER_WIDTH / STORE_COMMIT_THRESH constants used as parameter defaults
- One sub-module, sc_drain_entry: per-entry FSM with age and backoff counters, instantiated ENTRIES times.
- The top holds the round-robin selector, popcount threshold, output registers and proto_err.

Test Plan:
- Alloc entry 2 at cycle 0, no touch, cache_ready=1 → req_valid with req_idx=2 at cycle 7 (age 7→1 takes 6 cycles, then 1-cycle issue latency); writing_vec[2]=1; resp_success idx 2 → empty=1 next cycle.
- Alloc entry 0, touch it every 3 cycles for 20 cycles → no request during touches; request issued 7 cycles after the last touch.
- Alloc 7 entries (> THRESH=6) in one cycle, cache_ready=1 → 7 consecutive req_valid cycles starting 2 cycles later, indices 0..6 in order.
- Entry 4 WRITING, resp_conflict idx 4 → entry 4 reissued exactly 4 cycles after re-eligibility wait (backoff 3→0, then issue); no other entry is starved by the RR pointer.
- flush=1 with entries 1, 5 AGING (age 7), cache_ready held 0 for 3 cycles then 1 → reqs idx 1 then 5; drain_done=1 after both succeed.
- alloc_en to WRITING entry 3, or touch_en to FREE entry 6 → proto_err=1 and stays set; entry states unchanged; async rst clears it.
